// File: rtl/operand_loader.sv
// Operand-entry front end: synchronises and debounces the LOAD/CANCEL keys, then
// captures operand A and operand B from the switches and hands the pair off with valid/ack.
module operand_loader #(
  parameter int WIDTH        = 8,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             button0,
  input  logic             button1,
  input  logic             button2,
  input  logic [WIDTH-1:0] switch1,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_valid,
  input  logic             op_ack,
  output logic [2:0]       state_led
);

  // One-hot encoding so the state register doubles as the LED drive.
  typedef enum logic [2:0] {
    S_A     = 3'b001,
    S_B     = 3'b010,
    S_VALID = 3'b100
  } state_e;

  localparam int               KEY_LOAD   = 0;
  localparam int               KEY_CANCEL = 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic rst_n;
  assign rst_n = button0;

  logic [1:0]       key_raw;
  logic [1:0]       sync_r_q, sync_r_d;
  logic [1:0]       sync_rr_q, sync_rr_d;
  logic [1:0]       deb_q, deb_d;
  logic [1:0]       deb_prev_q, deb_prev_d;
  logic [1:0]       press_q, press_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  assign key_raw = {button2, button1};

  // Key conditioning: a level is accepted only after DEBOUNCE_CYC consecutive
  // synchronised samples disagree with the current accepted level.
  always_comb begin
    // NOTE: every signal gets its default before any branch, so no path can infer a latch.
    sync_r_d   = key_raw;
    sync_rr_d  = sync_r_q;
    deb_prev_d = deb_q;
    press_d    = deb_prev_q & ~deb_q;
    deb_d      = deb_q;
    for (int k = 0; k < 2; k++) begin
      cnt_d[k] = cnt_q[k];
      if (sync_rr_q[k] == deb_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CNT_LAST) begin
        deb_d[k] = sync_rr_q[k];
        cnt_d[k] = '0;
      end else begin
        cnt_d[k] = cnt_q[k] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Everything parks at "released" so leaving reset can never look like a press.
      sync_r_q   <= '1;
      sync_rr_q  <= '1;
      deb_q      <= '1;
      deb_prev_q <= '1;
      press_q    <= '0;
      for (int k = 0; k < 2; k++) cnt_q[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of order.
      sync_r_q   <= sync_r_d;
      sync_rr_q  <= sync_rr_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      press_q    <= press_d;
      for (int k = 0; k < 2; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             op_valid_q, op_valid_d;
  logic             load_press;
  logic             cancel_press;

  assign load_press   = press_q[KEY_LOAD];
  assign cancel_press = press_q[KEY_CANCEL];

  // Cancel is tested first in every state, so it beats both a load and an ack.
  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_valid_d = op_valid_q;
    case (state_q)
      S_A: begin
        if (cancel_press) begin
          op_a_d = '0;
        end else if (load_press) begin
          op_a_d  = switch1;
          state_d = S_B;
        end
      end
      S_B: begin
        if (cancel_press) begin
          op_a_d  = '0;
          state_d = S_A;
        end else if (load_press) begin
          op_b_d     = switch1;
          op_valid_d = 1'b1;
          state_d    = S_VALID;
        end
      end
      S_VALID: begin
        if (cancel_press) begin
          op_a_d     = '0;
          op_b_d     = '0;
          op_valid_d = 1'b0;
          state_d    = S_A;
        end else if (op_ack) begin
          op_valid_d = 1'b0;
          state_d    = S_A;
        end
      end
      default: begin
        op_valid_d = 1'b0;
        state_d    = S_A;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_A;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_valid_q <= op_valid_d;
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_valid  = op_valid_q;
  assign state_led = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader: directed scenarios plus a randomized run
// compared cycle by cycle against a sliding-window behavioural model.
module tb_operand_loader;

  localparam int WIDTH = 8;
  localparam int D     = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             button0;
  logic             button1;
  logic             button2;
  logic [WIDTH-1:0] switch1;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_valid;
  logic             op_ack;
  logic [2:0]       state_led;

  int checks   = 0;
  int failures = 0;

  operand_loader #(
    .WIDTH       (WIDTH),
    .DEBOUNCE_CYC(D),
    .CNT_W       (CNT_W)
  ) dut (
    .clk      (clk),
    .button0  (button0),
    .button1  (button1),
    .button2  (button2),
    .switch1  (switch1),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_valid (op_valid),
    .op_ack   (op_ack),
    .state_led(state_led)
  );

  always #5 clk = ~clk;

  // Reference model. A key level is accepted when the last D raw samples, seen two
  // edges late through the synchroniser, all disagree with the accepted level.
  // An accepted fall acts on the operand state two edges after acceptance.
  bit               hist [2][D+1];
  bit               m_deb [2];
  bit               fell_km1 [2];
  bit               fell_km2 [2];
  int               m_state;
  logic [WIDTH-1:0] m_a;
  logic [WIDTH-1:0] m_b;
  logic             m_valid;
  logic [2:0]       m_led;

  task automatic model_step();
    bit raw [2];
    bit act [2];
    bit all_diff;
    bit fall;
    raw[0] = button1;
    raw[1] = button2;
    if (!button0) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i <= D; i++) hist[k][i] = 1'b1;
        m_deb[k]    = 1'b1;
        fell_km1[k] = 1'b0;
        fell_km2[k] = 1'b0;
      end
      m_state = 0;
      m_a     = '0;
      m_b     = '0;
      m_valid = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        act[k]      = fell_km2[k];
        fell_km2[k] = fell_km1[k];
        all_diff    = 1'b1;
        for (int i = 1; i <= D; i++) if (hist[k][i] == m_deb[k]) all_diff = 1'b0;
        fall = 1'b0;
        if (all_diff) begin
          m_deb[k] = ~m_deb[k];
          fall     = (m_deb[k] == 1'b0);
        end
        fell_km1[k] = fall;
        for (int i = D; i >= 1; i--) hist[k][i] = hist[k][i-1];
        hist[k][0] = raw[k];
      end
      case (m_state)
        0: begin
          if (act[1]) m_a = '0;
          else if (act[0]) begin m_a = switch1; m_state = 1; end
        end
        1: begin
          if (act[1]) begin m_a = '0; m_state = 0; end
          else if (act[0]) begin m_b = switch1; m_valid = 1'b1; m_state = 2; end
        end
        default: begin
          if (act[1]) begin m_a = '0; m_b = '0; m_valid = 1'b0; m_state = 0; end
          else if (op_ack) begin m_valid = 1'b0; m_state = 0; end
        end
      endcase
    end
    m_led = 3'b001 << m_state;
  endtask

  always @(posedge clk) model_step();

  // Hold the chosen keys low for 'edges' sampling edges, release, then let them settle.
  task automatic press_key(input bit k1, input bit k2, input int edges);
    if (k1) button1 = 1'b0;
    if (k2) button2 = 1'b0;
    repeat (edges) @(negedge clk);
    button1 = 1'b1;
    button2 = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    button0 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (op_a !== 8'h00) begin failures++; $display("FAIL reset_op_a: got %h want 00", op_a); end
    checks++;
    if (op_b !== 8'h00) begin failures++; $display("FAIL reset_op_b: got %h want 00", op_b); end
    checks++;
    if (op_valid !== 1'b0) begin failures++; $display("FAIL reset_op_valid: got %b want 0", op_valid); end
    checks++;
    if (state_led !== 3'b001) begin failures++; $display("FAIL reset_state_led: got %b want 001", state_led); end
    button0 = 1'b1;
  endtask

  task automatic test_bounce();
    button1 = 1'b0;
    repeat (3) @(negedge clk);
    button1 = 1'b1;
    @(negedge clk);
    button1 = 1'b0;
    repeat (3) @(negedge clk);
    button1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (state_led !== 3'b001 || op_a !== 8'h00) begin
        failures++;
        $display("FAIL bounce_no_capture: got led=%b a=%h want led=001 a=00", state_led, op_a);
      end
    end
  endtask

  task automatic test_capture();
    switch1 = 8'h3C;
    button1 = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (op_a !== 8'h00) begin failures++; $display("FAIL capture_before_edge8: got %h want 00", op_a); end
    @(negedge clk);
    checks++;
    if (op_a !== 8'h3C) begin failures++; $display("FAIL capture_at_edge8: got %h want 3c", op_a); end
    checks++;
    if (state_led !== 3'b010) begin failures++; $display("FAIL capture_state_b: got %b want 010", state_led); end
    repeat (2) @(negedge clk);
    button1 = 1'b1;
    repeat (12) @(negedge clk);
    switch1 = 8'hA5;
    press_key(1'b1, 1'b0, 10);
    checks++;
    if ({op_a, op_b, op_valid, state_led} !== {8'h3C, 8'hA5, 1'b1, 3'b100}) begin
      failures++;
      $display("FAIL capture_pair: got a=%h b=%h v=%b led=%b want a=3c b=a5 v=1 led=100",
               op_a, op_b, op_valid, state_led);
    end
  endtask

  task automatic test_hold_ack();
    op_ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({op_a, op_b, op_valid, state_led} !== {8'h3C, 8'hA5, 1'b1, 3'b100}) begin
        failures++;
        $display("FAIL hold_until_ack: got a=%h b=%h v=%b led=%b want a=3c b=a5 v=1 led=100",
                 op_a, op_b, op_valid, state_led);
      end
    end
    op_ack = 1'b1;
    @(negedge clk);
    op_ack = 1'b0;
    checks++;
    if ({op_a, op_b, op_valid, state_led} !== {8'h3C, 8'hA5, 1'b0, 3'b001}) begin
      failures++;
      $display("FAIL ack_release: got a=%h b=%h v=%b led=%b want a=3c b=a5 v=0 led=001",
               op_a, op_b, op_valid, state_led);
    end
  endtask

  task automatic test_cancel();
    switch1 = 8'h11;
    press_key(1'b1, 1'b0, 10);
    checks++;
    if (op_a !== 8'h11 || state_led !== 3'b010) begin
      failures++;
      $display("FAIL cancel_setup: got a=%h led=%b want a=11 led=010", op_a, state_led);
    end
    press_key(1'b0, 1'b1, 10);
    checks++;
    if (op_a !== 8'h00 || state_led !== 3'b001) begin
      failures++;
      $display("FAIL cancel_in_b: got a=%h led=%b want a=00 led=001", op_a, state_led);
    end
    press_key(1'b1, 1'b1, 10);
    checks++;
    if ({op_a, op_b, op_valid, state_led} !== {8'h00, 8'hA5, 1'b0, 3'b001}) begin
      failures++;
      $display("FAIL cancel_beats_load: got a=%h b=%h v=%b led=%b want a=00 b=a5 v=0 led=001",
               op_a, op_b, op_valid, state_led);
    end
  endtask

  task automatic test_ack_cancel_collision();
    switch1 = 8'hFF;
    press_key(1'b1, 1'b0, 10);
    switch1 = 8'h01;
    press_key(1'b1, 1'b0, 10);
    checks++;
    if ({op_a, op_b, op_valid, state_led} !== {8'hFF, 8'h01, 1'b1, 3'b100}) begin
      failures++;
      $display("FAIL collision_setup: got a=%h b=%h v=%b led=%b want a=ff b=01 v=1 led=100",
               op_a, op_b, op_valid, state_led);
    end
    button2 = 1'b0;
    repeat (7) @(negedge clk);
    op_ack = 1'b1;
    @(negedge clk);
    op_ack = 1'b0;
    checks++;
    if ({op_a, op_b, op_valid, state_led} !== {8'h00, 8'h00, 1'b0, 3'b001}) begin
      failures++;
      $display("FAIL cancel_beats_ack: got a=%h b=%h v=%b led=%b want a=00 b=00 v=0 led=001",
               op_a, op_b, op_valid, state_led);
    end
    repeat (2) @(negedge clk);
    button2 = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_mid_handshake();
    switch1 = 8'hFF;
    press_key(1'b1, 1'b0, 10);
    switch1 = 8'h01;
    press_key(1'b1, 1'b0, 10);
    checks++;
    if (op_valid !== 1'b1 || state_led !== 3'b100) begin
      failures++;
      $display("FAIL reset_mid_setup: got v=%b led=%b want v=1 led=100", op_valid, state_led);
    end
    button0 = 1'b0;
    @(negedge clk);
    button0 = 1'b1;
    checks++;
    if ({op_a, op_b, op_valid, state_led} !== {8'h00, 8'h00, 1'b0, 3'b001}) begin
      failures++;
      $display("FAIL reset_mid_values: got a=%h b=%h v=%b led=%b want a=00 b=00 v=0 led=001",
               op_a, op_b, op_valid, state_led);
    end
    op_ack = 1'b1;
    @(negedge clk);
    op_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({op_a, op_b, op_valid, state_led} !== {8'h00, 8'h00, 1'b0, 3'b001}) begin
      failures++;
      $display("FAIL ack_ignored_in_a: got a=%h b=%h v=%b led=%b want a=00 b=00 v=0 led=001",
               op_a, op_b, op_valid, state_led);
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      checks++;
      if ({op_a, op_b, op_valid, state_led} !== {m_a, m_b, m_valid, m_led}) begin
        failures++;
        $display("FAIL random_cycle_%0d: got a=%h b=%h v=%b led=%b want a=%h b=%h v=%b led=%b",
                 n, op_a, op_b, op_valid, state_led, m_a, m_b, m_valid, m_led);
      end
      if (hold == 0) begin
        button1 = ($urandom_range(0, 1) == 0);
        button2 = ($urandom_range(0, 5) != 0);
        hold    = $urandom_range(1, 12);
        if ($urandom_range(0, 2) == 0) switch1 = 8'($urandom);
      end else begin
        hold--;
      end
      op_ack  = ($urandom_range(0, 5) == 0);
      button0 = ($urandom_range(0, 299) != 0);
    end
    button0 = 1'b1;
    button1 = 1'b1;
    button2 = 1'b1;
    op_ack  = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    button0 = 1'b0;
    button1 = 1'b1;
    button2 = 1'b1;
    op_ack  = 1'b0;
    switch1 = '0;
    test_reset();
    test_bounce();
    test_capture();
    test_hold_ack();
    test_cancel();
    test_ack_cancel_collision();
    test_reset_mid_handshake();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
